// File: rtl/uart_rx_pkg.sv
// Shared constants and helpers for the UART receive path.
// Sampling, counting and the frame checkers all import this package.
package uart_rx_pkg;

  localparam int unsigned PRESC_8             = 32'd8;
  localparam int unsigned PRESC_16            = 32'd16;
  localparam int unsigned PRESC_32            = 32'd32;
  localparam int unsigned UART_FRAME_BITS_MAX = 32'd11;
  localparam logic        IDLE_LEVEL          = 1'b1;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversample edge counter and frame bit counter for the UART receiver.
// The counters run while samp_en_i is high and clear as soon as it drops.
module uart_rx_edge_bit_cnt
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  samp_en_i,
  input  logic [PRESCALE_W-1:0] p_last_i,
  output logic [PRESCALE_W-1:0] edge_cnt_o,
  output logic [BIT_CNT_W-1:0]  bit_cnt_o,
  output logic                  bit_done_o
);

  logic [PRESCALE_W-1:0] edge_cnt_q;
  logic [PRESCALE_W-1:0] edge_cnt_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q;
  logic [BIT_CNT_W-1:0]  bit_cnt_d;
  logic                  bit_done_s;

  // Next-state for the counters; wrapping on >= keeps a mid-frame
  // prescale shrink from running the edge counter past the new limit.
  always_comb begin
    edge_cnt_d = edge_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    bit_done_s = 1'b0;
    if (!samp_en_i) begin
      edge_cnt_d = {PRESCALE_W{1'b0}};
      bit_cnt_d  = {BIT_CNT_W{1'b0}};
    end else if (edge_cnt_q >= p_last_i) begin
      edge_cnt_d = {PRESCALE_W{1'b0}};
      bit_cnt_d  = bit_cnt_q + BIT_CNT_W'(1);
      bit_done_s = (edge_cnt_q == p_last_i) ? 1'b1 : 1'b0;
    end else begin
      edge_cnt_d = edge_cnt_q + PRESCALE_W'(1);
      bit_cnt_d  = bit_cnt_q;
    end
  end

  // Counter state registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      edge_cnt_q <= {PRESCALE_W{1'b0}};
      bit_cnt_q  <= {BIT_CNT_W{1'b0}};
    end else begin
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

  assign edge_cnt_o = edge_cnt_q;
  assign bit_cnt_o  = bit_cnt_q;
  assign bit_done_o = bit_done_s;

endmodule

// File: rtl/uart_rx_data_sampling.sv
// UART RX front end: two-flop synchroniser, oversampling counters and a
// three-sample majority vote around mid-bit.
module uart_rx_data_sampling
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  samp_en,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BIT_CNT_W-1:0]  bit_cnt,
  output logic                  bit_done,
  output logic                  sampled_bit,
  output logic                  sample_valid
);

  logic                  sync1_q;
  logic                  sync2_q;
  logic                  rx_s;
  logic [PRESCALE_W-1:0] p_eff_s;
  logic [PRESCALE_W-1:0] p_last_s;
  logic [PRESCALE_W-1:0] mid_s;
  logic [PRESCALE_W-1:0] mid_m1_s;
  logic [PRESCALE_W-1:0] mid_m2_s;
  logic                  s0_q;
  logic                  s0_d;
  logic                  s1_q;
  logic                  s1_d;
  logic                  sampled_bit_q;
  logic                  sampled_bit_d;
  logic                  sample_valid_q;
  logic                  sample_valid_d;

  // Two-flop synchroniser for the asynchronous serial line.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= IDLE_LEVEL;
      sync2_q <= IDLE_LEVEL;
    end else begin
      sync1_q <= rx_in;
      sync2_q <= sync1_q;
    end
  end

  assign rx_s = sync2_q;

  // Unsupported ratios fall back to 8 so the counters always have a sane limit.
  always_comb begin
    p_eff_s = PRESCALE_W'(PRESC_8);
    case (prescale)
      PRESCALE_W'(PRESC_8):  p_eff_s = PRESCALE_W'(PRESC_8);
      PRESCALE_W'(PRESC_16): p_eff_s = PRESCALE_W'(PRESC_16);
      PRESCALE_W'(PRESC_32): p_eff_s = PRESCALE_W'(PRESC_32);
      default:               p_eff_s = PRESCALE_W'(PRESC_8);
    endcase
  end

  assign p_last_s = p_eff_s - PRESCALE_W'(1);
  assign mid_s    = p_eff_s >> 1;
  assign mid_m1_s = mid_s - PRESCALE_W'(1);
  assign mid_m2_s = mid_s - PRESCALE_W'(2);

  uart_rx_edge_bit_cnt #(
    .PRESCALE_W (PRESCALE_W),
    .BIT_CNT_W  (BIT_CNT_W)
  ) u_edge_bit_cnt (
    .clk        (clk),
    .rst        (rst),
    .samp_en_i  (samp_en),
    .p_last_i   (p_last_s),
    .edge_cnt_o (edge_cnt),
    .bit_cnt_o  (bit_cnt),
    .bit_done_o (bit_done)
  );

  // Capture samples at M-2 and M-1, vote at M; a vote is dropped if
  // samp_en falls in that same cycle.
  always_comb begin
    s0_d           = s0_q;
    s1_d           = s1_q;
    sampled_bit_d  = sampled_bit_q;
    sample_valid_d = 1'b0;
    if (samp_en) begin
      if (edge_cnt == mid_m2_s) begin
        s0_d = rx_s;
      end else if (edge_cnt == mid_m1_s) begin
        s1_d = rx_s;
      end else if (edge_cnt == mid_s) begin
        sampled_bit_d  = majority3(s0_q, s1_q, rx_s);
        sample_valid_d = 1'b1;
      end else begin
        s0_d = s0_q;
        s1_d = s1_q;
      end
    end else begin
      s0_d = IDLE_LEVEL;
      s1_d = IDLE_LEVEL;
    end
  end

  // Sample and vote result registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s0_q           <= IDLE_LEVEL;
      s1_q           <= IDLE_LEVEL;
      sampled_bit_q  <= IDLE_LEVEL;
      sample_valid_q <= 1'b0;
    end else begin
      s0_q           <= s0_d;
      s1_q           <= s1_d;
      sampled_bit_q  <= sampled_bit_d;
      sample_valid_q <= sample_valid_d;
    end
  end

  assign sampled_bit  = sampled_bit_q;
  assign sample_valid = sample_valid_q;

endmodule

// File: tb/tb_uart_rx_data_sampling.sv
// Directed self-checking bench for uart_rx_data_sampling.
module tb_uart_rx_data_sampling;

  localparam int PW = 6;
  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_in;
  logic [PW-1:0] prescale;
  logic          samp_en;
  logic [PW-1:0] edge_cnt;
  logic [BW-1:0] bit_cnt;
  logic          bit_done;
  logic          sampled_bit;
  logic          sample_valid;

  int checks_total  = 0;
  int checks_passed = 0;

  logic [10:0] frame;
  logic        fbit;

  uart_rx_data_sampling #(.PRESCALE_W(PW), .BIT_CNT_W(BW)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_in        (rx_in),
    .prescale     (prescale),
    .samp_en      (samp_en),
    .edge_cnt     (edge_cnt),
    .bit_cnt      (bit_cnt),
    .bit_done     (bit_done),
    .sampled_bit  (sampled_bit),
    .sample_valid (sample_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic lvl, input int n);
    samp_en = 1'b0;
    rx_in   = lvl;
    repeat (n) tick();
  endtask

  // One full bit: rx_in in cycle e is pat[e]; rx_s lags it by two cycles.
  task automatic run_bit(input int p, input logic [31:0] pat, input logic exp_bit, input int bcnt);
    for (int e = 0; e < p; e++) begin
      rx_in   = pat[e];
      samp_en = 1'b1;
      check("edge_cnt", edge_cnt, e);
      check("bit_cnt", bit_cnt, bcnt & 15);
      check("bit_done", bit_done, (e == p - 1));
      check("sample_valid", sample_valid, (e == p / 2 + 1));
      if (e == p / 2 + 1) check("sampled_bit", sampled_bit, exp_bit);
      tick();
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_edge_cnt"}, edge_cnt, 0);
    check({tag, "_bit_cnt"}, bit_cnt, 0);
    check({tag, "_sampled_bit"}, sampled_bit, 1);
    check({tag, "_sample_valid"}, sample_valid, 0);
    check({tag, "_bit_done"}, bit_done, 0);
  endtask

  initial begin
    // Reset with line low and enable high.
    rst      = 1'b0;
    rx_in    = 1'b0;
    samp_en  = 1'b1;
    prescale = 6'd8;
    repeat (2) tick();
    check_reset_state("reset");
    rst = 1'b1;

    // P=8, line low: vote at 5, wrap after 7.
    idle(1'b0, 3);
    run_bit(8, 32'h0000_0000, 1'b0, 0);
    run_bit(8, 32'h0000_0000, 1'b0, 1);
    check("p8_bit_cnt_after2", bit_cnt, 2);
    check("p8_edge_after2", edge_cnt, 0);

    // P=16 glitches: single one-sample glitch is outvoted, two-sample wins.
    prescale = 6'd16;
    idle(1'b0, 3);
    check("p16_cleared_bit_cnt", bit_cnt, 0);
    run_bit(16, 32'h0000_0020, 1'b0, 0);
    run_bit(16, 32'h0000_0030, 1'b1, 1);

    // P=32, 11-bit frame delivered bit by bit.
    prescale = 6'd32;
    frame    = 11'b0_10110011_1_1;
    idle(1'b1, 3);
    for (int i = 0; i < 11; i++) begin
      fbit = frame[10 - i];
      run_bit(32, fbit ? 32'hFFFF_FFFF : 32'h0000_0000, fbit, i);
    end
    check("p32_bit_cnt_end", bit_cnt, 11);
    check("p32_edge_end", edge_cnt, 0);

    // Illegal prescale acts as 8.
    prescale = 6'd12;
    idle(1'b1, 3);
    run_bit(8, 32'hFFFF_FFFF, 1'b1, 0);
    check("p12_wrap_edge", edge_cnt, 0);
    check("p12_wrap_bit_cnt", bit_cnt, 1);

    // samp_en drops on the vote edge: vote discarded, counters clear.
    prescale = 6'd8;
    idle(1'b0, 3);
    samp_en = 1'b1;
    repeat (4) tick();
    check("drop_edge_before", edge_cnt, 4);
    samp_en = 1'b0;
    tick();
    check("drop_sample_valid", sample_valid, 0);
    check("drop_sampled_bit_held", sampled_bit, 1);
    check("drop_edge_cnt", edge_cnt, 0);
    check("drop_bit_cnt", bit_cnt, 0);
    check("drop_bit_done", bit_done, 0);
    tick();
    check("drop_sample_valid_late", sample_valid, 0);
    check("drop_sampled_bit_late", sampled_bit, 1);

    // Reset asserted mid-bit after a 0 has been voted.
    idle(1'b0, 3);
    samp_en = 1'b1;
    repeat (6) tick();
    check("midrst_pre_sampled_bit", sampled_bit, 0);
    check("midrst_pre_edge", edge_cnt, 6);
    rst = 1'b0;
    tick();
    check_reset_state("midrst");
    rst     = 1'b1;
    samp_en = 1'b0;
    tick();

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
